// File: rtl/radio_ctrl_sync.sv
// radio_ctrl_sync: carries NUM_CH asynchronous radio control bits into the
// clk domain through a SYNC_STAGES-flop synchroniser and a per-channel
// debounce filter. It produces registered rise/fall event pulses.
// While iso_i is high the outputs clamp to CLAMP_VAL. After release, a settle
// phase runs before the outputs track the inputs again.
// Optional build macro: RADIO_SYNC_GLITCH_CNT_EN adds an aborted-debounce
// counter (glitch_clr_i / glitch_cnt_o).
module radio_ctrl_sync #(
  parameter int unsigned       NUM_CH       = 2,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       DEBOUNCE_CYC = 0,
  parameter logic [NUM_CH-1:0] CLAMP_VAL    = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              iso_i,
  input  logic [NUM_CH-1:0] async_i,
  output logic [NUM_CH-1:0] sync_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              ready_o
`ifdef RADIO_SYNC_GLITCH_CNT_EN
  ,
  input  logic              glitch_clr_i,
  output logic [7:0]        glitch_cnt_o
`endif
);

  localparam int unsigned CW         = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int unsigned SETTLE_LEN = SYNC_STAGES + DEBOUNCE_CYC;
  localparam int unsigned SW         = $clog2(SETTLE_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(DEBOUNCE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_RUN, ST_ISO} state_e;

  state_e                             state_q, state_d;
  logic [SW-1:0]                      settle_q, settle_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] chain_q, chain_d;
  logic [NUM_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  out_q, out_d;
  logic [NUM_CH-1:0]                  rise_q, rise_d;
  logic [NUM_CH-1:0]                  fall_q, fall_d;
  logic [NUM_CH-1:0]                  s;

  // Synchroniser shift chain; stage 1 sees the clamp value while isolated.
  always_comb begin
    chain_d[0] = iso_i ? CLAMP_VAL : async_i;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  assign s = chain_q[SYNC_STAGES-1];

  // Next-state, debounce and event logic. Isolation overrides everything last.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rise_d   = '0;
    fall_d   = '0;
    case (state_q)
      ST_RUN: begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
          if (s[ch] != out_q[ch]) begin
            if (cnt_q[ch] == CNT_MAX) begin
              out_d[ch]  = s[ch];
              cnt_d[ch]  = '0;
              rise_d[ch] = s[ch];
              fall_d[ch] = ~s[ch];
            end else begin
              cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
          end else begin
            cnt_d[ch] = '0;
          end
        end
      end
      ST_ISO: begin
        out_d = CLAMP_VAL;
        cnt_d = '0;
        if (!iso_i) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        cnt_d    = '0;
        settle_d = settle_q + SW'(1);
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end
      end
    endcase
    // The clamp beats a debounce completing on the same edge; no pulse escapes.
    if (iso_i) begin
      state_d  = ST_ISO;
      settle_d = '0;
      out_d    = CLAMP_VAL;
      cnt_d    = '0;
      rise_d   = '0;
      fall_d   = '0;
    end
  end

  // State, synchroniser, counters and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      chain_q  <= '0;
      cnt_q    <= '0;
      out_q    <= CLAMP_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sync_o  = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign ready_o = (state_q == ST_RUN);

`ifdef RADIO_SYNC_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // Saturating sum of debounces aborted by the synced value reverting.
  always_comb begin
    glitch_d = glitch_q;
    if (state_q == ST_RUN) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if ((cnt_q[ch] != '0) && (s[ch] == out_q[ch]) && (glitch_d != 8'hFF)) begin
          glitch_d = glitch_d + 8'd1;
        end
      end
    end
    if (glitch_clr_i) begin
      glitch_d = '0;
    end
  end

  // Glitch counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: doc/radio_ctrl_sync.md
Name: radio_ctrl_sync

Overview:
Parametrised successor to the single-stage radio-control resynchroniser. Carries NUM_CH asynchronous radio control bits (radioEnable, radioRxEn, …) into the timing-engine clock domain through an N-flop synchroniser and a per-channel debounce filter, and produces one-cycle rise/fall event pulses. Adds power-isolation awareness: while the source domain is isolated, outputs clamp to a defined value, and on release a settle phase runs before outputs are trusted again.

Parameters:
NUM_CH, 2, number of control channels
SYNC_STAGES, 2, synchroniser flops per channel (min 2)
DEBOUNCE_CYC, 0, cycles the synced value must differ from the current output before the output updates (0 = no filtering)
CLAMP_VAL, {NUM_CH{1'b0}}, per-channel value driven during isolation and after reset

Ports:
clk  in  1  timing-engine clock
arst  in  1  reset, asynchronous, active-high
iso_i  in  1  source-domain isolation request, synchronous to clk
async_i  in  NUM_CH  unsynchronised control bits from the source domain
sync_o  out  NUM_CH  synchronised, debounced control bits
rise_o  out  NUM_CH  one-cycle pulse when sync_o[i] goes 0->1
fall_o  out  NUM_CH  one-cycle pulse when sync_o[i] goes 1->0
ready_o  out  1  high when outputs track inputs (state RUN)

Behaviour:
- Reset (arst=1): sync chain all 0, debounce counters 0, sync_o=CLAMP_VAL, rise_o=fall_o=0, ready_o=0, state=SETTLE, settle counter 0.
- Sync chain: stage 1 samples async_i, or CLAMP_VAL while iso_i=1. The last stage is s[i].
- Debounce counter cnt[i], width $clog2(DEBOUNCE_CYC+1), evaluated per edge:
  - In RUN with s[i]!=sync_o[i]: if cnt[i]==DEBOUNCE_CYC, then sync_o[i]<=s[i] and cnt[i]<=0; otherwise cnt[i]++.
  - If s[i]==sync_o[i]: cnt[i]<=0.
- Latency in RUN: async_i change to sync_o change is SYNC_STAGES+DEBOUNCE_CYC+1 clk edges. Any reversion of s[i] before the count completes aborts the update (glitch rejected).
- rise_o/fall_o are registered and high for exactly the one cycle in which sync_o[i] first shows its new value. They are never asserted outside RUN.
- State machine:
  - RUN: normal operation, ready_o=1. iso_i=1 goes to ISO.
  - ISO: on each edge, sync_o<=CLAMP_VAL and all cnt<=0; no pulses; ready_o=0. iso_i=0 goes to SETTLE with the settle counter cleared.
  - SETTLE: sync_o held; cnt held at 0; no pulses; ready_o=0; the settle counter increments. On reaching SYNC_STAGES+DEBOUNCE_CYC, go to RUN. iso_i=1 during SETTLE goes to ISO immediately.
- Entering RUN: any s[i]!=sync_o[i] is then debounced normally and produces the matching rise/fall pulse.
- Simultaneous events: iso_i=1 takes priority over a completing debounce on the same edge; the clamp wins and no pulse is emitted.
- All channels are independent; multiple channels may pulse on the same cycle.
- arst mid-operation: immediate return to reset values regardless of state.

Optional Feature:
RADIO_SYNC_GLITCH_CNT_EN
- Defined: adds ports glitch_clr_i (in, 1) and glitch_cnt_o (out, 8).
  - glitch_cnt_o is an 8-bit saturating count of aborted debounces, all channels summed: in RUN, a cycle where cnt[i]!=0 and s[i]==sync_o[i]. Several channels aborting on the same edge add their number, saturating at 255.
  - glitch_clr_i=1 zeroes the count; it has priority over an increment on the same edge.
  - Reset value 0.
- Undefined: neither port exists and the logic is absent; behaviour is otherwise identical.

Test Plan:
1. NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYC=3, CLAMP_VAL=0. Release arst with async_i=0 -> ready_o rises 5 cycles after release; sync_o=0; no pulses.
2. In RUN, step async_i[0] 0->1 and hold -> sync_o[0]=1 exactly 6 edges later; rise_o[0] high for one cycle on that same cycle; channel 1 unaffected.
3. In RUN, pulse async_i[1]=1 for 2 cycles -> sync_o[1] stays 0, no rise_o[1]. With RADIO_SYNC_GLITCH_CNT_EN, glitch_cnt_o increments by 1.
4. sync_o=2'b11, assert iso_i for 4 cycles -> sync_o=00 one edge after iso_i, ready_o=0, no fall pulses. After iso_i drops (async_i=11), hold 5 settle cycles, then RUN; sync_o returns to 11 after a further 4 edges with rise_o=11 for one cycle.
5. Reassert iso_i during SETTLE -> immediate ISO, ready_o stays 0, settle restarts from 0 on the next release.
6. Assert arst mid-debounce (cnt[0]=2) -> sync_o=CLAMP_VAL, ready_o=0, no pulse. With the feature, glitch_clr_i with a simultaneous abort -> glitch_cnt_o=0.
